// File: rtl/seg_display_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_display_driver_if                                         |
// | Brief    : number_to_display bus and 7-segment pin bundle                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface seg_display_driver_if;
   logic [10:0] number_to_display;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        conv_done;

   modport master (output number_to_display, input seg, an, dp, conv_done);
   modport slave  (input number_to_display, output seg, an, dp, conv_done);
endinterface
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_display_driver                                            |
// | Brief    : double-dabble BCD converter + 4-digit multiplexed 7-seg scan;  |
// |            SEG_DISPLAY_NEG_BLINK_EN enables blinking of negative values  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg_display_driver #(
   parameter int DIGIT_PERIOD = 100000,
   parameter int BLINK_SCANS  = 64
) (
   input  logic                gameClk,
   input  logic                rst_n,
   seg_display_driver_if.slave bus
);

   localparam int                 c_cnt_w     = $clog2(DIGIT_PERIOD);
   localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(DIGIT_PERIOD - 1);
   localparam logic [3:0]         c_code_dash = 4'hA;
   localparam logic [3:0]         c_code_blnk = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_capture;
   logic                w_shift;
   logic                w_latch;

   logic [10:0]         r_shadow;
   logic                r_pending;
   logic                r_sign;
   logic [10:0]         r_mag;
   logic [15:0]         r_bcd;
   logic [3:0]          r_step;
   logic [3:0][3:0]     r_disp;
   logic                r_conv_done;

   logic [10:0]         w_abs;
   logic [15:0]         w_bcd_adj;
   logic [3:0][3:0]     w_fmt;

   logic [c_cnt_w-1:0]  r_scan_cnt;
   logic [1:0]          r_idx;
   logic [3:0]          r_an;
   logic [6:0]          r_seg;
   logic                w_blink;

   function automatic logic [6:0] f_seg7(input logic [3:0] code);
      case (code)
         4'd0:        f_seg7 = 7'b1000000;
         4'd1:        f_seg7 = 7'b1111001;
         4'd2:        f_seg7 = 7'b0100100;
         4'd3:        f_seg7 = 7'b0110000;
         4'd4:        f_seg7 = 7'b0011001;
         4'd5:        f_seg7 = 7'b0010010;
         4'd6:        f_seg7 = 7'b0000010;
         4'd7:        f_seg7 = 7'b1111000;
         4'd8:        f_seg7 = 7'b0000000;
         4'd9:        f_seg7 = 7'b0010000;
         c_code_dash: f_seg7 = 7'b0111111;
         default:     f_seg7 = 7'b1111111;
      endcase
   endfunction

   // 11-bit unsigned is enough: |-1024| = 1024 = 11'b100_0000_0000
   assign w_abs = bus.number_to_display[10] ? (~bus.number_to_display + 11'd1)
                                            : bus.number_to_display;

   always_ff @(posedge gameClk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_shift     = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pending || (bus.number_to_display != r_shadow)) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_step == 4'd10) w_state_nxt = ST_LATCH;
         end
         ST_LATCH: begin
            w_latch     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_fmt = {4{c_code_blnk}};
      if (!r_sign) begin
         w_fmt[3] = (r_bcd[15:12] == 4'd0) ? c_code_blnk : r_bcd[15:12];
         w_fmt[2] = (r_bcd[15:8]  == 8'd0) ? c_code_blnk : r_bcd[11:8];
         w_fmt[1] = (r_bcd[15:4]  == 12'd0) ? c_code_blnk : r_bcd[7:4];
         w_fmt[0] = r_bcd[3:0];
      end else if (r_bcd[15:12] != 4'd0) begin
         w_fmt = {4{c_code_dash}};
      end else begin
         w_fmt[3] = c_code_dash;
         w_fmt[2] = (r_bcd[11:8] == 4'd0) ? c_code_blnk : r_bcd[11:8];
         w_fmt[1] = (r_bcd[11:4] == 8'd0) ? c_code_blnk : r_bcd[7:4];
         w_fmt[0] = r_bcd[3:0];
      end
   end

   always_ff @(posedge gameClk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow    <= 11'd0;
         r_pending   <= 1'b1;
         r_sign      <= 1'b0;
         r_mag       <= 11'd0;
         r_bcd       <= 16'd0;
         r_step      <= 4'd0;
         r_disp      <= {4{c_code_blnk}};
         r_conv_done <= 1'b0;
      end else begin
         r_conv_done <= w_latch;
         if (w_capture) begin
            r_shadow  <= bus.number_to_display;
            r_sign    <= bus.number_to_display[10];
            r_mag     <= w_abs;
            r_bcd     <= 16'd0;
            r_step    <= 4'd0;
            r_pending <= 1'b0;
         end
         if (w_shift) begin
            r_bcd  <= {w_bcd_adj[14:0], r_mag[10]};
            r_mag  <= {r_mag[9:0], 1'b0};
            r_step <= r_step + 4'd1;
         end
         if (w_latch) r_disp <= w_fmt;
      end
   end

`ifdef SEG_DISPLAY_NEG_BLINK_EN
   localparam int                   c_blink_w   = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_SCANS - 1);

   logic                 r_disp_neg;
   logic                 r_blink;
   logic [c_blink_w-1:0] r_blink_cnt;
   logic                 w_scan_wrap;

   assign w_scan_wrap = (r_scan_cnt == c_cnt_max) && (r_idx == 2'd3);
   assign w_blink     = r_blink;

   always_ff @(posedge gameClk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_neg  <= 1'b0;
         r_blink     <= 1'b0;
         r_blink_cnt <= '0;
      end else begin
         if (w_latch) r_disp_neg <= r_sign;
         if (w_latch && !r_sign) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
         end else if (r_disp_neg && w_scan_wrap) begin
            if (r_blink_cnt == c_blink_max) begin
               r_blink_cnt <= '0;
               r_blink     <= ~r_blink;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end
      end
   end
`else
   // BLINK_SCANS is always >= 1, so this is a constant 0
   assign w_blink = (BLINK_SCANS < 0);
`endif

   // an and seg share one register stage so they always switch together
   always_ff @(posedge gameClk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= 2'd0;
         r_an       <= 4'hF;
         r_seg      <= 7'h7F;
      end else begin
         if (r_scan_cnt == c_cnt_max) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         if (w_blink) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
         end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= f_seg7(r_disp[r_idx]);
         end
      end
   end

   assign bus.seg       = r_seg;
   assign bus.an        = r_an;
   assign bus.dp        = 1'b1;
   assign bus.conv_done = r_conv_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg_display_driver                                         |
// | Brief    : vector table + scoreboard bench for seg_display_driver        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_seg_display_driver;
   localparam int DP    = 4;
   localparam int SCAN  = 4 * DP;
   localparam int BLINK_N = 2;
`ifdef SEG_DISPLAY_NEG_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S7 = 7'b1111000, S9 = 7'b0010000,
                          SD = 7'b0111111, SB = 7'b1111111;

   logic gameClk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 gameClk = ~gameClk;

   seg_display_driver_if dif ();

   seg_display_driver #(
      .DIGIT_PERIOD (DP),
      .BLINK_SCANS  (BLINK_N)
   ) dut (
      .gameClk (gameClk),
      .rst_n   (rst_n),
      .bus     (dif)
   );

   typedef struct {
      logic [10:0] value;
      logic [27:0] segs;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cycle  = 0;
   logic [27:0] exp_q[$];
   int          done_cycle[$];

   always @(posedge gameClk) cycle <= cycle + 1;

   function automatic logic [27:0] segs4(input logic [6:0] d3, d2, d1, d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic wait_convs(input int n, input string name);
      int start;
      int k;
      start = done_cycle.size();
      k = 0;
      while (done_cycle.size() < start + n && k < 80) begin
         @(negedge gameClk);
         k++;
      end
      check({name, "_conv_timeout"}, 32'(done_cycle.size() >= start + n), 32'd1);
   endtask

   task automatic settle();
      repeat (SCAN + 4) @(negedge gameClk);
   endtask

   // Scoreboard: on each conv_done, pop the expectation and compare one scan
   initial begin : monitor
      logic [27:0] e_segs;
      logic [6:0]  got [4];
      bit          seen [4];
      bit          carry;
      int          idx;
      carry = 1'b0;
      forever begin
         if (!carry) begin
            @(negedge gameClk);
            if (dif.conv_done !== 1'b1) continue;
         end
         carry = 1'b0;
         done_cycle.push_back(cycle);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_conv_done: got pulse at cycle %0d expected none", cycle);
            continue;
         end
         e_segs = exp_q.pop_front();
         for (int i = 0; i < 4; i++) seen[i] = 1'b0;
         @(negedge gameClk);
         check("conv_done_width", 32'(dif.conv_done), 32'd0);
         check("dp_off", 32'(dif.dp), 32'd1);
         for (int c = 0; c < SCAN; c++) begin
            if (c > 0) @(negedge gameClk);
            if (dif.conv_done === 1'b1) begin
               carry = 1'b1;
               break;
            end
            idx = -1;
            case (dif.an)
               4'b1110: idx = 0;
               4'b1101: idx = 1;
               4'b1011: idx = 2;
               4'b0111: idx = 3;
               4'b1111: if (!BLINK) begin
                  checks++; errors++;
                  $display("FAIL an_onehot: got %b expected one-hot low", dif.an);
               end
               default: begin
                  checks++; errors++;
                  $display("FAIL an_onehot: got %b expected one-hot low", dif.an);
               end
            endcase
            if (idx >= 0) begin
               got[idx]  = dif.seg;
               seen[idx] = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (seen[i]) begin
               check($sformatf("digit%0d_seg", i), 32'(got[i]), 32'(e_segs[7*i +: 7]));
            end else if (!carry && !BLINK) begin
               checks++; errors++;
               $display("FAIL digit%0d_seen: got none expected %b", i, e_segs[7*i +: 7]);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish before 400000");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      vec_t vecs [9];
      int   n_before;
      int   bad;
      int   n;

      vecs[0] = '{11'(-25),   segs4(SD, SB, S2, S5)};
      vecs[1] = '{11'd1023,   segs4(S1, S0, S2, S3)};
      vecs[2] = '{11'd0,      segs4(SB, SB, SB, S0)};
      vecs[3] = '{11'(-999),  segs4(SD, S9, S9, S9)};
      vecs[4] = '{11'd105,    segs4(SB, S1, S0, S5)};
      vecs[5] = '{11'(-7),    segs4(SD, SB, SB, S7)};
      vecs[6] = '{11'd1000,   segs4(S1, S0, S0, S0)};
      vecs[7] = '{11'(-1000), segs4(SD, SD, SD, SD)};
      vecs[8] = '{11'(-1024), segs4(SD, SD, SD, SD)};

      dif.number_to_display = 11'd20;
      rst_n = 1'b0;
      repeat (3) @(negedge gameClk);
      check("reset_seg", 32'(dif.seg), 32'h7F);
      check("reset_an", 32'(dif.an), 32'hF);
      check("reset_dp", 32'(dif.dp), 32'd1);
      check("reset_conv_done", 32'(dif.conv_done), 32'd0);

      // First conversion after reset: done visible after the 13th edge
      exp_q.push_back(segs4(SB, SB, S2, S0));
      rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge gameClk);
         if (k == 12) check("latency_not_early", 32'(dif.conv_done), 32'd0);
         if (k == 13) check("latency_13", 32'(dif.conv_done), 32'd1);
      end
      settle();

      for (int i = 0; i < 9; i++) begin
         @(negedge gameClk);
         dif.number_to_display = vecs[i].value;
         exp_q.push_back(vecs[i].segs);
         wait_convs(1, $sformatf("vec%0d", i));
         settle();
      end

      // Input changes at SHIFT step 5: old value latched, new one follows
      n_before = done_cycle.size();
      @(negedge gameClk);
      dif.number_to_display = 11'd20;
      exp_q.push_back(segs4(SB, SB, S2, S0));
      repeat (6) @(negedge gameClk);
      dif.number_to_display = 11'(-25);
      exp_q.push_back(segs4(SD, SB, S2, S5));
      wait_convs(2, "midchange");
      if (done_cycle.size() >= n_before + 2)
         check("midchange_gap", 32'(done_cycle[n_before + 1] - done_cycle[n_before]), 32'd13);
      settle();
      repeat (30) @(negedge gameClk);
      check("midchange_two_pulses", 32'(done_cycle.size() - n_before), 32'd2);

      // Reset during SHIFT step 6 aborts, then a fresh conversion completes
      @(negedge gameClk);
      dif.number_to_display = 11'(-999);
      exp_q.push_back(segs4(SD, S9, S9, S9));
      repeat (7) @(negedge gameClk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_seg", 32'(dif.seg), 32'h7F);
      check("async_reset_an", 32'(dif.an), 32'hF);
      check("async_reset_done", 32'(dif.conv_done), 32'd0);
      @(negedge gameClk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge gameClk);
         if (dif.seg !== 7'h7F) bad++;
      end
      check("no_partial_digits", 32'(bad), 32'd0);
      wait_convs(1, "post_reset");
      settle();

`ifdef SEG_DISPLAY_NEG_BLINK_EN
      @(negedge gameClk);
      dif.number_to_display = 11'(-25);
      exp_q.push_back(segs4(SD, SB, S2, S5));
      wait_convs(1, "blink");
      settle();
      n = 0;
      while (dif.an === 4'hF && n < 200) begin @(negedge gameClk); n++; end
      n = 0;
      while (dif.an !== 4'hF && n < 200) begin @(negedge gameClk); n++; end
      n = 0;
      while (dif.an === 4'hF && n < 200) begin @(negedge gameClk); n++; end
      check("blink_off_len", 32'(n), 32'(BLINK_N * SCAN));
      n = 0;
      while (dif.an !== 4'hF && n < 200) begin @(negedge gameClk); n++; end
      check("blink_on_len", 32'(n), 32'(BLINK_N * SCAN));
      @(negedge gameClk);
      dif.number_to_display = 11'd20;
      exp_q.push_back(segs4(SB, SB, S2, S0));
      wait_convs(1, "unblink");
      settle();
      n = 0;
      for (int k = 0; k < 4 * BLINK_N * SCAN; k++) begin
         @(negedge gameClk);
         if (dif.an === 4'hF) n++;
      end
      check("steady_after_nonneg", 32'(n), 32'd0);
`endif

      repeat (5) @(negedge gameClk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
